// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner:
// dark segment pattern, FSM encodings and counter sizing.
package hex_display_scanner_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // Number of bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= max_val) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Value-side and pin-side signals of the display scanner; the producer/bench
// holds the master end, the scanner the slave end.
interface hex_display_scanner_if
  import hex_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   dig_n;
  seg_t                    seg_n;
  logic                    frame_done;

  modport master (
    output enable, load, value, lz_suppress,
    input  dig_n, seg_n, frame_done
  );

  modport slave (
    input  enable, load, value, lz_suppress,
    output dig_n, seg_n, frame_done
  );
endinterface

// File: rtl/hex_display_scanner_hex_decoder.sv
// Hex nibble to active-low seven-segment decoder; c0 is the nibble MSB,
// seg[k] drives segment k (a..g = seg0..seg6).
module hex_decoder
  import hex_display_scanner_pkg::*;
(
  input  logic c0,
  input  logic c1,
  input  logic c2,
  input  logic c3,
  output seg_t seg
);
  nibble_t code_s;

  assign code_s = {c0, c1, c2, c3};

  // Glyph lookup, bit pattern is {g,f,e,d,c,b,a} with 0 = lit.
  always_comb begin
    seg = SEG_OFF;
    case (code_s)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed refresh controller for a common-anode seven-segment display:
// one shared decoder, blanking guard before each digit, frame-synchronous updates.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  hex_display_scanner_if.slave bus
);
  localparam int CNT_W = width_for(max2(REFRESH_DIV, BLANK_CYCLES));
  localparam int IDX_W = width_for(NUM_DIGITS - 1);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [1:0]            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [VAL_W-1:0]      active_r;
  logic [VAL_W-1:0]      shadow_r;
  logic                  pending_r;
  logic                  frame_done_r;

  logic [1:0]            state_nx_s;
  logic [IDX_W-1:0]      idx_nx_s;
  logic [CNT_W-1:0]      cnt_nx_s;
  logic                  wrap_s;
  logic [NUM_DIGITS-1:0] blank_s;
  nibble_t               cur_nibble_s;
  logic                  cur_blank_s;
  seg_t                  dec_seg_s;
  logic [NUM_DIGITS-1:0] dig_s;
  seg_t                  seg_s;

  // Scan sequencing: IDLE -> BLANK guard -> SHOW slot -> next digit; enable low always wins.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    cnt_nx_s   = cnt_r;
    wrap_s     = 1'b0;
    if (!bus.enable) begin
      state_nx_s = ST_IDLE;
      idx_nx_s   = '0;
      cnt_nx_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_BLANK;
          idx_nx_s   = '0;
          cnt_nx_s   = '0;
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nx_s = ST_SHOW;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_nx_s = ST_BLANK;
            cnt_nx_s   = '0;
            if (idx_r == IDX_LAST) begin
              idx_nx_s = '0;
              wrap_s   = 1'b1;
            end else begin
              idx_nx_s = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nx_s = ST_BLANK;
          idx_nx_s   = '0;
          cnt_nx_s   = '0;
        end
      endcase
    end
  end

  // Scan state registers; frame_done is the registered wrap strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_BLANK;
      idx_r        <= '0;
      cnt_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      idx_r        <= idx_nx_s;
      cnt_r        <= cnt_nx_s;
      frame_done_r <= wrap_s;
    end
  end

  // Value path: loads park in shadow and only reach the display at a frame wrap
  // (or straight away while idle), so a frame never shows a torn value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_r  <= '0;
      shadow_r  <= '0;
      pending_r <= 1'b0;
    end else if (wrap_s) begin
      if (bus.load) begin
        active_r <= bus.value;
        shadow_r <= bus.value;
      end else if (pending_r) begin
        active_r <= shadow_r;
      end else begin
        active_r <= active_r;
      end
      pending_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (bus.load) begin
        active_r  <= bus.value;
        shadow_r  <= bus.value;
        pending_r <= 1'b0;
      end else if (pending_r) begin
        active_r  <= shadow_r;
        pending_r <= 1'b0;
      end else begin
        pending_r <= 1'b0;
      end
    end else if (bus.load) begin
      shadow_r  <= bus.value;
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero; digit 0 never is.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_lsd
      assign blank_s[gi] = 1'b0;
    end else begin : g_upper
      assign blank_s[gi] = bus.lz_suppress && (active_r[VAL_W-1:4*gi] == '0);
    end
  end

  // Select the nibble and blank flag of the digit currently being scanned.
  always_comb begin
    cur_nibble_s = '0;
    cur_blank_s  = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      cur_nibble_s = (idx_r == IDX_W'(d)) ? active_r[4*d +: 4] : cur_nibble_s;
      cur_blank_s  = (idx_r == IDX_W'(d)) ? blank_s[d]         : cur_blank_s;
    end
  end

  hex_decoder u_hex_decoder (
    .c0  (cur_nibble_s[3]),
    .c1  (cur_nibble_s[2]),
    .c2  (cur_nibble_s[1]),
    .c3  (cur_nibble_s[0]),
    .seg (dec_seg_s)
  );

  // Pin drive: only a non-suppressed SHOW slot lights anything.
  always_comb begin
    dig_s = '1;
    seg_s = SEG_OFF;
    if ((state_r == ST_SHOW) && !cur_blank_s) begin
      dig_s = ~(NUM_DIGITS'(1) << idx_r);
      seg_s = dec_seg_s;
    end else begin
      dig_s = '1;
      seg_s = SEG_OFF;
    end
  end

  assign bus.dig_n      = dig_s;
  assign bus.seg_n      = seg_s;
  assign bus.frame_done = frame_done_r;

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

- Time-multiplexed refresh controller for a multi-digit common-anode seven-segment display.
- One `hex_decoder` instance is shared across `NUM_DIGITS` digits: the block scans the digits in turn, feeds each nibble to the decoder, and drives the matching active-low digit enable.
- Sits between the value-producing logic and the board display pins.
- Provides glitch-free, frame-synchronous value updates, inter-digit blanking and optional leading-zero suppression.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned (2..8).
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit per slot (≥1).
- `BLANK_CYCLES`, default 2: all-off guard cycles before each digit slot (≥1), anti-ghosting.

Ports:
- `clk`  in  1  system clock; everything is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset; one clock domain only.
- `enable`  in  1  scan enable; 0 forces the display dark.
- `load`  in  1  single-cycle strobe: capture `value`.
- `value`  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is rightmost/least significant.
- `lz_suppress`  in  1  1 = blank leading zero digits.
- `dig_n`  out  NUM_DIGITS  active-low digit enables; at most one bit is 0.
- `seg_n`  out  7  active-low segments; `seg_n[k]` = decoder segment k (seg0..seg6).
- `frame_done`  out  1  one-cycle pulse at the end of each complete frame.

## Operation

- Registers:
  - `shadow` (load capture) and `pending` flag.
  - `active` (displayed value).
  - `idx` (current digit).
  - `cnt` (slot counter).
  - `state`: IDLE, BLANK, SHOW.
- Reset:
  - `state`=BLANK, `idx`=0, `cnt`=0, `active`=0, `shadow`=0, `pending`=0.
  - Outputs: `dig_n` all 1, `seg_n`=7'h7F, `frame_done`=0.
- IDLE (`enable`=0):
  - `dig_n` all 1, `seg_n`=7'h7F, `idx`=0.
  - A pending load commits to `active` immediately.
  - When `enable` rises, go to BLANK with `idx`=0, `cnt`=0.
- BLANK:
  - `dig_n` all 1, `seg_n`=7'h7F for `BLANK_CYCLES` cycles, then go to SHOW.
- SHOW:
  - Drive `dig_n[idx]`=0 and `seg_n` = `hex_decoder(active nibble idx)` for `REFRESH_DIV` cycles.
  - Decoder inputs: MSB of the nibble → `c0`, LSB → `c3`.
  - At slot end, go to BLANK and set `idx`=`idx`+1.
- Frame wrap: at the end of the SHOW slot with `idx`=`NUM_DIGITS`-1:
  - `idx` wraps to 0 and `frame_done` pulses on that edge.
  - If `pending`, copy `shadow`→`active` and clear `pending`.
- Load:
  - `load`=1 captures `value` into `shadow` and sets `pending`, in any state.
  - Repeated loads within a frame: the last one wins.
  - `load` in the same cycle as the wrap edge: the incoming `value` commits directly to `active`; `pending` ends 0.
- Leading-zero suppression (`lz_suppress`=1):
  - Digit i is blanked when nibbles i..`NUM_DIGITS`-1 of `active` are all 0 and i≠0.
  - Digit 0 is always shown.
  - A blanked digit keeps its slot timing but holds `dig_n` all 1 and `seg_n`=7'h7F.
- `enable` falling in any state: on the next edge go to IDLE and turn outputs dark. `frame_done` does not pulse for a partial frame.

## Timing

- Outputs are decoded from registered state only (`state`, `idx`, `active`), so they change only on clock edges and are glitch-free.
- Slot length: `BLANK_CYCLES` + `REFRESH_DIV` cycles.
- Frame length: `NUM_DIGITS`·(`BLANK_CYCLES`+`REFRESH_DIV`) cycles.
- Load-to-display latency: from the next wrap edge, at most one frame plus one cycle.
- `resetn` asserted mid-frame: outputs go dark asynchronously with no clock required; scanning restarts at digit 0 BLANK after release.
- `cnt` width: clog2(max(`REFRESH_DIV`,`BLANK_CYCLES`)+1).
- `idx` width: clog2(`NUM_DIGITS`), minimum 1.

## Structure

- The shared Verilog include holds `SEG_OFF` (7'h7F) and the three state encodings (IDLE/BLANK/SHOW).
- Single sub-module: one instance of the existing `hex_decoder`.
- The slot counter and the leading-zero mask generate loop stay inline; there is no further hierarchy.

## Test plan

Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=4, `BLANK_CYCLES`=1, so one frame = 20 cycles.

1. Reset, including an async assert mid-SHOW → `dig_n`=4'b1111, `seg_n`=7'h7F, `frame_done`=0 before any clock edge.
2. Load 16'h1234 in IDLE, then `enable`=1 → 1 blank cycle, then `dig_n`=4'b1110 with `seg_n`=7'b0011001 ("4") for 4 cycles. The next slots show 3, 2, 1 on `dig_n` 1101, 1011, 0111. `frame_done` pulses every 20 cycles.
3. `lz_suppress`=1 with 16'h0050 → digits 3 and 2 stay dark in their slots; digit 1 shows "5"; digit 0 shows "0" (`seg_n`=7'b1000000). With 16'h0000, only digit 0 lights.
4. Load 16'hABCD at frame cycle 7 → the old value persists through the frame, `frame_done` pulses, and 'D' shows from the next frame. Load asserted on the wrap edge → commits that same edge.
5. `enable` dropped mid-SHOW of digit 2 → next edge `dig_n`=4'b1111 and no `frame_done`. Re-enable → the scan restarts at digit 0 BLANK.
6. Two loads in one frame (16'h1111, then 16'h2222) → only 16'h2222 is ever displayed.
